// File: rtl/input_debouncer.sv
// Debounces a raw bouncing button into a clean synchronous level.
// Ports: clk, reset (sync, active-high), btn_in -> w_out, rise, fall, state.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       w_out,
  output logic       rise,
  output logic       fall,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_LOW    = 2'b00,
    S_WAIT_H = 2'b01,
    S_HIGH   = 2'b10,
    S_WAIT_L = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             w_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cur   <= S_LOW;
      cnt   <= '0;
      w_out <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      cur   <= nxt;
      cnt   <= cnt_nxt;
      w_out <= w_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Entry into a WAIT state counts as the first stable sample,
  // so the count runs 0..DEBOUNCE_CYCLES-1 inside WAIT.
  always_comb begin
    nxt      = cur;
    cnt_nxt  = cnt;
    w_nxt    = w_out;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    unique case (cur)
      S_LOW: begin
        if (sync2) begin
          nxt     = S_WAIT_H;
          cnt_nxt = '0;
        end
      end
      S_WAIT_H: begin
        if (!sync2) begin
          nxt = S_LOW;
        end else if (cnt == CNT_LAST) begin
          nxt      = S_HIGH;
          w_nxt    = 1'b1;
          rise_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync2) begin
          nxt     = S_WAIT_L;
          cnt_nxt = '0;
        end
      end
      S_WAIT_L: begin
        if (sync2) begin
          nxt = S_HIGH;
        end else if (cnt == CNT_LAST) begin
          nxt      = S_LOW;
          w_nxt    = 1'b0;
          fall_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        nxt = S_LOW;
      end
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: two instances (D=4, D=1) vs a run-length model.
// Directed scenarios followed by randomized bouncing with sporadic resets.
module tb_input_debouncer;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       w_a, rise_a, fall_a;
  logic       w_b, rise_b, fall_b;
  logic [1:0] st_a, st_b;

  int ncmp;
  int nfail;

  input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst), .btn_in(btn),
    .w_out(w_a), .rise(rise_a), .fall(fall_a), .state(st_a)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst), .btn_in(btn),
    .w_out(w_b), .rise(rise_b), .fall(fall_b), .state(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the output level flips once the synchronized input has
  // disagreed with it for D+1 consecutive edges; any agreement resets.
  int   dcyc [2];
  int   m_run[2];
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_w  [2];
  logic m_r  [2];
  logic m_f  [2];

  task automatic model_edge(input int i, input logic r, input logic b);
    if (r) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_run[i] = 0;
      m_w[i] = 1'b0; m_r[i] = 1'b0; m_f[i] = 1'b0;
    end else begin
      m_r[i] = 1'b0;
      m_f[i] = 1'b0;
      if (m_s2[i] != m_w[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == dcyc[i] + 1) begin
          m_w[i] = ~m_w[i];
          if (m_w[i]) m_r[i] = 1'b1;
          else m_f[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = b;
    end
  endtask

  function automatic logic [1:0] exp_state(input int i);
    return {m_w[i], (m_run[i] != 0)};
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs,
                     input logic [1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w_a", {1'b0, w_a}, {1'b0, m_w[0]});
    chk("rise_a", {1'b0, rise_a}, {1'b0, m_r[0]});
    chk("fall_a", {1'b0, fall_a}, {1'b0, m_f[0]});
    chk("state_a", st_a, exp_state(0));
    chk("w_b", {1'b0, w_b}, {1'b0, m_w[1]});
    chk("rise_b", {1'b0, rise_b}, {1'b0, m_r[1]});
    chk("fall_b", {1'b0, fall_b}, {1'b0, m_f[1]});
    chk("state_b", st_b, exp_state(1));
    chk("excl_a", {1'b0, rise_a & fall_a}, 2'b00);
    chk("excl_b", {1'b0, rise_b & fall_b}, 2'b00);
  endtask

  task automatic step(input logic r, input logic b);
    rst = r;
    btn = b;
    @(posedge clk);
    model_edge(0, r, b);
    model_edge(1, r, b);
    #1;
    check_all();
  endtask

  initial begin
    logic [6:0] bounce;
    ncmp  = 0;
    nfail = 0;
    dcyc[0] = 4;
    dcyc[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_run[i] = 0;
      m_w[i] = 1'b0; m_r[i] = 1'b0; m_f[i] = 1'b0;
    end
    rst = 1'b1;
    btn = 1'b1;

    // reset held with button pressed, then release
    repeat (3) step(1'b1, 1'b1);
    chk("rst_state_a", st_a, 2'b00);
    chk("rst_w_a", {1'b0, w_a}, 2'b00);
    repeat (10) step(1'b0, 1'b1);

    // release to low, then a clean press with explicit latency check
    repeat (12) step(1'b0, 1'b0);
    for (int j = 0; j <= 20; j++) begin
      step(1'b0, 1'b1);
      if (j == 5) chk("lat_a_pre", {1'b0, w_a}, 2'b00);
      if (j == 6) chk("lat_a_rise", {w_a, rise_a}, 2'b11);
      if (j == 2) chk("lat_b_pre", {1'b0, w_b}, 2'b00);
      if (j == 3) chk("lat_b_rise", {w_b, rise_b}, 2'b11);
    end

    // release with a single-cycle glitch mid-WAIT_L
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("glitch_a_hold", {1'b0, w_a}, 2'b01);
    repeat (12) step(1'b0, 1'b0);
    chk("release_a", {1'b0, w_a}, 2'b00);

    // bounce: 1,1,0,1,1,1,0 then 0
    bounce = 7'b1101110;
    for (int j = 6; j >= 0; j--) step(1'b0, bounce[j]);
    repeat (10) step(1'b0, 1'b0);
    chk("bounce_a_low", {w_a, st_a[0]}, 2'b00);

    // reset mid WAIT_H, then reset in HIGH
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_wait_a", st_a, 2'b00);
    repeat (12) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_high_a", {w_a, fall_a}, 2'b00);
    repeat (12) step(1'b0, 1'b1);

    // randomized bouncing with occasional reset
    for (int n = 0; n < 80; n++) begin
      int   len;
      logic lvl;
      len = $urandom_range(1, 9);
      lvl = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        step(($urandom_range(0, 59) == 0), lvl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
